// File: rtl/sm_hex_display_scan.sv
// ============================================================================
//  Module      : sm_hex_display_scan
//  Description : Time-multiplexed 8-digit hex seven-segment scanner with
//                per-frame input snapshot, per-digit decimal points and
//                ghost blanking on every digit change.
//                Optional leading-zero blanking: define SM_HEX_LZB_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sm_hex_display_scan #(
    parameter int DIGITS     = 8,
    parameter int PRESCALE   = 16,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dotMask,
    output logic [6:0]            seg,
    output logic                  dot,
    output logic [DIGITS-1:0]     anodes,
    output logic                  frame
);

    localparam int                 c_idx_w    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(DIGITS - 1);
    localparam logic               c_pol      = (ACTIVE_LOW != 0);

    function automatic logic [6:0] f_hex7(input logic [3:0] n);
        logic [6:0] p;
        case (n)
            4'h0: p = 7'h3F;  4'h1: p = 7'h06;  4'h2: p = 7'h5B;  4'h3: p = 7'h4F;
            4'h4: p = 7'h66;  4'h5: p = 7'h6D;  4'h6: p = 7'h7D;  4'h7: p = 7'h07;
            4'h8: p = 7'h7F;  4'h9: p = 7'h6F;  4'hA: p = 7'h77;  4'hB: p = 7'h7C;
            4'hC: p = 7'h39;  4'hD: p = 7'h5E;  4'hE: p = 7'h79;  default: p = 7'h71;
        endcase
        return p;
    endfunction

    logic [PRESCALE-1:0] r_cntr_q,         w_cntr_d;
    logic [c_idx_w-1:0]  r_idx_q,          w_idx_d;
    logic [4*DIGITS-1:0] r_data_s_q,       w_data_s_d;
    logic [DIGITS-1:0]   r_dot_s_q,        w_dot_s_d;
    logic                r_load_pending_q, w_load_pending_d;
    logic [6:0]          r_seg_q,          w_seg_d;
    logic                r_dot_q,          w_dot_d;
    logic [DIGITS-1:0]   r_anodes_q,       w_anodes_d;
    logic                r_frame_q,        w_frame_d;

    logic                w_tick;
    logic                w_load;
    logic [DIGITS-1:0]   w_blank_mask;
    logic [DIGITS-1:0]   w_onehot;
    logic [3:0]          w_nibble;
    logic                w_dot_sel;
    logic                w_blank_sel;

    // Blank mask derives from the shadow registers, so it only moves at snapshots.
`ifdef SM_HEX_LZB_EN
    logic [DIGITS:1] w_zero_up;
    assign w_zero_up[DIGITS] = 1'b1;
    assign w_blank_mask[0]   = 1'b0;
    for (genvar gi = 1; gi < DIGITS; gi++) begin : g_lzb
        assign w_zero_up[gi]    = w_zero_up[gi+1] && (r_data_s_q[4*gi +: 4] == 4'h0);
        assign w_blank_mask[gi] = w_zero_up[gi] && !r_dot_s_q[gi];
    end
`else
    assign w_blank_mask = '0;
`endif

    always_comb begin
        w_tick           = &r_cntr_q;
        w_load           = (w_tick && (r_idx_q == c_idx_last)) || r_load_pending_q;
        w_cntr_d         = r_cntr_q + 1'b1;
        w_idx_d          = r_idx_q;
        if (w_tick) begin
            w_idx_d = (r_idx_q == c_idx_last) ? '0 : r_idx_q + 1'b1;
        end
        w_data_s_d       = w_load ? data    : r_data_s_q;
        w_dot_s_d        = w_load ? dotMask : r_dot_s_q;
        w_load_pending_d = 1'b0;
        w_frame_d        = w_load;
    end

    // Digit select as an explicit mux so a non-power-of-2 DIGITS never indexes out of range.
    always_comb begin
        w_nibble    = 4'h0;
        w_dot_sel   = 1'b0;
        w_blank_sel = 1'b0;
        w_onehot    = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx_q == c_idx_w'(i)) begin
                w_nibble    = r_data_s_q[4*i +: 4];
                w_dot_sel   = r_dot_s_q[i];
                w_blank_sel = w_blank_mask[i];
                w_onehot[i] = 1'b1;
            end
        end
    end

    // Tick cycle forces all-inactive outputs to hide ghosting between digits.
    always_comb begin
        w_seg_d    = {7{c_pol}};
        w_dot_d    = c_pol;
        w_anodes_d = {DIGITS{c_pol}};
        if (!w_tick) begin
            w_seg_d    = (w_blank_sel ? 7'h00 : f_hex7(w_nibble)) ^ {7{c_pol}};
            w_dot_d    = w_dot_sel ^ c_pol;
            w_anodes_d = w_onehot ^ {DIGITS{c_pol}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cntr_q         <= '0;
            r_idx_q          <= '0;
            r_data_s_q       <= '0;
            r_dot_s_q        <= '0;
            r_load_pending_q <= 1'b1;
            r_seg_q          <= {7{c_pol}};
            r_dot_q          <= c_pol;
            r_anodes_q       <= {DIGITS{c_pol}};
            r_frame_q        <= 1'b0;
        end else begin
            r_cntr_q         <= w_cntr_d;
            r_idx_q          <= w_idx_d;
            r_data_s_q       <= w_data_s_d;
            r_dot_s_q        <= w_dot_s_d;
            r_load_pending_q <= w_load_pending_d;
            r_seg_q          <= w_seg_d;
            r_dot_q          <= w_dot_d;
            r_anodes_q       <= w_anodes_d;
            r_frame_q        <= w_frame_d;
        end
    end

    assign seg    = r_seg_q;
    assign dot    = r_dot_q;
    assign anodes = r_anodes_q;
    assign frame  = r_frame_q;

endmodule

`default_nettype wire

// File: tb/tb_sm_hex_display_scan.sv
// ============================================================================
//  Module      : tb_sm_hex_display_scan
//  Description : Directed self-checking bench for sm_hex_display_scan
//                (PRESCALE=2, DIGITS=8, ACTIVE_LOW=1).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sm_hex_display_scan;

    localparam int DIGITS     = 8;
    localparam int PRESCALE   = 2;
    localparam int ACTIVE_LOW = 1;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic [31:0] data     = 32'h0;
    logic [7:0]  dot_mask = 8'h0;
    logic [6:0]  seg;
    logic        dot;
    logic [7:0]  anodes;
    logic        frame;

    int total = 0;
    int bad   = 0;
    int k     = 0;   // clock edges since reset release

    sm_hex_display_scan #(
        .DIGITS     (DIGITS),
        .PRESCALE   (PRESCALE),
        .ACTIVE_LOW (ACTIVE_LOW)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .data    (data),
        .dotMask (dot_mask),
        .seg     (seg),
        .dot     (dot),
        .anodes  (anodes),
        .frame   (frame)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] p;
        case (n)
            4'h0: p = 7'h3F;  4'h1: p = 7'h06;  4'h2: p = 7'h5B;  4'h3: p = 7'h4F;
            4'h4: p = 7'h66;  4'h5: p = 7'h6D;  4'h6: p = 7'h7D;  4'h7: p = 7'h07;
            4'h8: p = 7'h7F;  4'h9: p = 7'h6F;  4'hA: p = 7'h77;  4'hB: p = 7'h7C;
            4'hC: p = 7'h39;  4'hD: p = 7'h5E;  4'hE: p = 7'h79;  default: p = 7'h71;
        endcase
        return p;
    endfunction

    // Expected {seg,dot,anodes} after edge kk: every 4th edge is a blank tick,
    // otherwise digit (kk/4)%8 of the snapshot is shown.
    function automatic logic [15:0] exp_out(input int kk, input logic [31:0] snap,
                                            input logic [7:0] dm);
        int         d;
        logic [3:0] nib;
        logic [6:0] pat;
        logic [7:0] an;
        logic       blank;
        if (kk % 4 == 0) return {7'h7F, 1'b1, 8'hFF};
        d     = (kk / 4) % 8;
        nib   = 4'(snap >> (4 * d));
        pat   = hex7(nib);
        an    = 8'h01 << d;
        blank = 1'b0;
`ifdef SM_HEX_LZB_EN
        if (d > 0 && (snap >> (4 * d)) == 32'h0 && dm[d] == 1'b0) blank = 1'b1;
`endif
        if (blank) pat = 7'h00;
        return {~pat, ~dm[d], ~an};
    endfunction

    task automatic adv();
        @(negedge clk);
        k++;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        data     = 32'h01234567;
        dot_mask = 8'h00;
        repeat (3) @(negedge clk);
        total++;
        if ({seg, dot, anodes, frame} !== {7'h7F, 1'b1, 8'hFF, 1'b0}) begin
            bad++;
            $display("FAIL reset_hold: got %h want %h", {seg, dot, anodes, frame},
                     {7'h7F, 1'b1, 8'hFF, 1'b0});
        end
        rst = 1'b0;
        k   = 0;
        #1;
        total++;
        if ({seg, dot, anodes, frame} !== {7'h7F, 1'b1, 8'hFF, 1'b0}) begin
            bad++;
            $display("FAIL reset_release: got %h want %h", {seg, dot, anodes, frame},
                     {7'h7F, 1'b1, 8'hFF, 1'b0});
        end
        adv();
        total++;
        if ({anodes, frame} !== {8'hFE, 1'b1}) begin
            bad++;
            $display("FAIL first_load: got anodes=%h frame=%b want anodes=fe frame=1",
                     anodes, frame);
        end
        adv();
        total++;
        if ({seg, dot, anodes, frame} !== {7'h78, 1'b1, 8'hFE, 1'b0}) begin
            bad++;
            $display("FAIL first_digit: got %h want %h", {seg, dot, anodes, frame},
                     {7'h78, 1'b1, 8'hFE, 1'b0});
        end
    endtask

    task automatic test_scan();
        while (k < 33) begin
            adv();
            total++;
            if ({seg, dot, anodes, frame} !== {exp_out(k, 32'h01234567, 8'h00), (k % 32 == 0)}) begin
                bad++;
                $display("FAIL scan k=%0d: got %h want %h", k, {seg, dot, anodes, frame},
                         {exp_out(k, 32'h01234567, 8'h00), (k % 32 == 0)});
            end
        end
    endtask

    task automatic test_snapshot();
        logic [31:0] snap;
        while (k < 72) begin
            adv();
            snap = (k <= 64) ? 32'h01234567 : 32'hFFFFFFFF;
            total++;
            if ({seg, dot, anodes, frame} !== {exp_out(k, snap, 8'h00), (k % 32 == 0)}) begin
                bad++;
                $display("FAIL snapshot k=%0d: got %h want %h", k, {seg, dot, anodes, frame},
                         {exp_out(k, snap, 8'h00), (k % 32 == 0)});
            end
            if (k == 45) data = 32'hFFFFFFFF;
        end
    endtask

    task automatic test_dots();
        logic [7:0] dm;
        dot_mask = 8'h81;
        while (k < 128) begin
            adv();
            dm = (k <= 96) ? 8'h00 : 8'h81;
            total++;
            if ({seg, dot, anodes, frame} !== {exp_out(k, 32'hFFFFFFFF, dm), (k % 32 == 0)}) begin
                bad++;
                $display("FAIL dots k=%0d: got %h want %h", k, {seg, dot, anodes, frame},
                         {exp_out(k, 32'hFFFFFFFF, dm), (k % 32 == 0)});
            end
        end
    endtask

    task automatic test_mid_reset();
        while (k < 149) adv();
        total++;
        if (anodes !== 8'hDF) begin
            bad++;
            $display("FAIL pre_reset_digit5: got anodes=%h want df", anodes);
        end
        rst      = 1'b1;
        data     = 32'h89ABCDEF;
        dot_mask = 8'h00;
        adv();
        total++;
        if ({seg, dot, anodes, frame} !== {7'h7F, 1'b1, 8'hFF, 1'b0}) begin
            bad++;
            $display("FAIL mid_reset: got %h want %h", {seg, dot, anodes, frame},
                     {7'h7F, 1'b1, 8'hFF, 1'b0});
        end
        adv();
        rst = 1'b0;
        k   = 0;
        adv();
        total++;
        if ({anodes, frame} !== {8'hFE, 1'b1}) begin
            bad++;
            $display("FAIL restart_load: got anodes=%h frame=%b want anodes=fe frame=1",
                     anodes, frame);
        end
        while (k < 40) begin
            adv();
            total++;
            if ({seg, dot, anodes, frame} !== {exp_out(k, 32'h89ABCDEF, 8'h00), (k % 32 == 0)}) begin
                bad++;
                $display("FAIL restart k=%0d: got %h want %h", k, {seg, dot, anodes, frame},
                         {exp_out(k, 32'h89ABCDEF, 8'h00), (k % 32 == 0)});
            end
        end
    endtask

    task automatic test_leading(input logic [31:0] value, input logic [7:0] dm);
        rst      = 1'b1;
        data     = value;
        dot_mask = dm;
        adv();
        adv();
        rst = 1'b0;
        k   = 0;
        adv();
        while (k < 32) begin
            adv();
            total++;
            if ({seg, dot, anodes, frame} !== {exp_out(k, value, dm), (k % 32 == 0)}) begin
                bad++;
                $display("FAIL leading v=%h dm=%h k=%0d: got %h want %h", value, dm, k,
                         {seg, dot, anodes, frame}, {exp_out(k, value, dm), (k % 32 == 0)});
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_snapshot();
        test_dots();
        test_mid_reset();
        test_leading(32'h000000A0, 8'h00);
        test_leading(32'h00000000, 8'h00);
        test_leading(32'h000000A0, 8'h10);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
